// File: rtl/store_commit_buffer_if.sv
// Store-queue to dcache bundle: committed-store ports with their accepts,
// the memory write port driven from the buffer head, and the load snoop ports.
interface store_commit_buffer_if #(
  parameter int NUM_PORTS = 2,
  parameter int NUM_LD    = 2
);

  // SQ_DCACHE_PACKET; sign_size is MEM_FUNC: [2] sign, [1:0] size (0 byte, 1 half, 2 word)
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  sign_size;
    logic [31:0] data;
  } sq_dcache_packet_t;

  sq_dcache_packet_t [NUM_PORTS-1:0] sq_dcache_packet;
  logic [NUM_PORTS-1:0]              dcache_accept;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready;

  logic [NUM_LD-1:0][31:0] ld_addr;
  logic [NUM_LD-1:0][3:0]  fwd_mask;
  logic [NUM_LD-1:0][31:0] fwd_data;

  // Store queue, memory and load pipeline side
  modport master (
    output sq_dcache_packet, mem_req_ready, ld_addr,
    input  dcache_accept, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    input  fwd_mask, fwd_data
  );

  // Commit buffer side
  modport slave (
    input  sq_dcache_packet, mem_req_ready, ld_addr,
    output dcache_accept, mem_req_valid, mem_req_addr, mem_req_data, mem_req_be,
    output fwd_mask, fwd_data
  );

endinterface

// File: rtl/store_commit_buffer.sv
// In-order write buffer between store-queue retirement and the memory write
// port. Accepts an in-order prefix of committed stores per cycle, coalesces
// into the youngest non-head entry, drains one entry per handshake and lets
// loads snoop the buffered bytes.
module store_commit_buffer #(
  parameter int  NUM_PORTS = 2,  // NUM_SQ_DCACHE
  parameter int  DEPTH     = 4,  // power of two, >= 2
  parameter int  NUM_LD    = 2,  // NUM_FU_LOAD
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  store_commit_buffer_if.slave bus,
  output logic [CNT_W-1:0]     count,
  output logic                 empty
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  logic [DEPTH-1:0] r_valid;
  entry_t           r_entry [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0]     w_valid_n;
  entry_t               w_entry_n [DEPTH];
  logic [PTR_W-1:0]     w_tail_n;
  logic [CNT_W-1:0]     w_count_n;
  logic [NUM_PORTS-1:0] w_accept;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_free;
  logic [CNT_W-1:0]     w_allocs;
  logic [PTR_W-1:0]     w_young;
  logic                 w_young_ok;
  logic                 w_stop;
  logic [3:0]           w_be;
  logic [31:0]          w_data;

  logic [NUM_LD-1:0][3:0]  w_fwd_mask;
  logic [NUM_LD-1:0][31:0] w_fwd_data;
  logic                    w_unused;

  // Place a store's bytes at their lanes within the word; returns {be, data}
  function automatic logic [35:0] realign(input logic [1:0]  size,
                                          input logic [1:0]  off,
                                          input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] wd;
    case (size)
      SZ_BYTE: begin
        be = 4'b0001 << off;
        wd = {24'b0, d[7:0]} << {off, 3'b000};
      end
      SZ_HALF: begin
        be = 4'b0011 << {off[1], 1'b0};
        wd = {16'b0, d[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        be = 4'hF;
        wd = d;
      end
    endcase
    return {be, wd};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Accept prefix, merge/allocate in port order, head pop and next count
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave one unassigned, which would otherwise infer a latch.
    w_valid_n  = r_valid;
    w_entry_n  = r_entry;
    w_tail_n   = r_tail;
    w_accept   = '0;
    w_free     = CNT_W'(DEPTH) - r_count;
    w_allocs   = '0;
    w_stop     = reset;
    w_young    = r_tail - PTR_W'(1);
    w_young_ok = (r_count != '0);
    w_be       = '0;
    w_data     = '0;
    // NOTE: blocking assignments here model ordering within the cycle: port
    // i+1 sees the entry port i just merged into or allocated.
    for (int i = 0; i < NUM_PORTS; i++) begin
      {w_be, w_data} = realign(bus.sq_dcache_packet[i].sign_size[1:0],
                               bus.sq_dcache_packet[i].addr[1:0],
                               bus.sq_dcache_packet[i].data);
      if (!w_stop && bus.sq_dcache_packet[i].valid) begin
        if (w_young_ok && (w_young != r_head) &&
            (w_entry_n[w_young].waddr == bus.sq_dcache_packet[i].addr[31:2])) begin
          w_accept[i]               = 1'b1;
          w_entry_n[w_young].be     = w_entry_n[w_young].be | w_be;
          w_entry_n[w_young].data   = (w_entry_n[w_young].data & ~byte_mask(w_be)) | w_data;
        end else if (w_allocs < w_free) begin
          w_accept[i]               = 1'b1;
          w_valid_n[w_tail_n]       = 1'b1;
          w_entry_n[w_tail_n].waddr = bus.sq_dcache_packet[i].addr[31:2];
          w_entry_n[w_tail_n].be    = w_be;
          w_entry_n[w_tail_n].data  = w_data;
          w_young                   = w_tail_n;
          w_young_ok                = 1'b1;
          w_tail_n                  = w_tail_n + PTR_W'(1);
          w_allocs                  = w_allocs + CNT_W'(1);
        end else begin
          w_stop = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
    // A slot freed by this pop is only offered to stores from the next cycle
    w_pop = (r_count != '0) && bus.mem_req_ready && !reset;
    if (w_pop) w_valid_n[r_head] = 1'b0;
    w_count_n = r_count + w_allocs - CNT_W'(w_pop);
  end

  // Control state: valid bits, pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
      if (w_pop) r_head <= r_head + PTR_W'(1);
    end
  end

  // Entry payload storage
  // NOTE: the payload array is left out of reset; r_valid and r_count gate
  // every use of it, so clearing it would only add reset fan-out.
  always_ff @(posedge clock) begin
    r_entry <= w_entry_n;
  end

  // Per-byte forwarding from the youngest buffered entry that wrote the byte
  always_comb begin
    w_fwd_mask = '0;
    w_fwd_data = '0;
    for (int n = 0; n < NUM_LD; n++) begin
      for (int k = 0; k < DEPTH; k++) begin
        // Walk oldest to youngest so a later hit overrides an earlier one
        if (r_valid[r_head + PTR_W'(k)] &&
            (r_entry[r_head + PTR_W'(k)].waddr == bus.ld_addr[n][31:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (r_entry[r_head + PTR_W'(k)].be[b]) begin
              w_fwd_mask[n][b]       = 1'b1;
              w_fwd_data[n][8*b +: 8] = r_entry[r_head + PTR_W'(k)].data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Sign bits and the load byte offset carry no information for this block
  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) w_unused = w_unused ^ bus.sq_dcache_packet[i].sign_size[2];
    for (int n = 0; n < NUM_LD; n++) w_unused = w_unused ^ (^bus.ld_addr[n][1:0]);
  end

  assign bus.dcache_accept = w_accept;
  assign bus.mem_req_valid = (r_count != '0);
  assign bus.mem_req_addr  = {r_entry[r_head].waddr, 2'b00};
  assign bus.mem_req_data  = r_entry[r_head].data;
  assign bus.mem_req_be    = r_entry[r_head].be;
  assign bus.fwd_mask      = w_fwd_mask;
  assign bus.fwd_data      = w_fwd_data;
  assign count             = r_count;
  assign empty             = (r_count == '0);

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the buffer contents.
module tb_store_commit_buffer;

  localparam int NP = 2;
  localparam int D  = 4;
  localparam int NL = 2;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] count;
  logic          empty;

  store_commit_buffer_if #(.NUM_PORTS(NP), .NUM_LD(NL)) sif ();

  store_commit_buffer #(.NUM_PORTS(NP), .DEPTH(D), .NUM_LD(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif.slave),
    .count (count),
    .empty (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];       // oldest at index 0
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte lanes a store of the given size writes, from the aligned base lane upward
  function automatic void place(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                                output logic [3:0] be, output logic [31:0] wd);
    int n;
    int off;
    int base;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    base = (off / n) * n;
    be   = '0;
    wd   = '0;
    for (int k = 0; k < n; k++) begin
      be[base+k]            = 1'b1;
      wd[8*(base+k) +: 8]   = d[8*k +: 8];
    end
  endfunction

  task automatic set_port(input int p, input bit v, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d);
    sif.sq_dcache_packet[p].valid     = v;
    sif.sq_dcache_packet[p].addr      = a;
    sif.sq_dcache_packet[p].sign_size = {1'($urandom_range(0, 1)), sz};
    sif.sq_dcache_packet[p].data      = d;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 32'h0, 2'd2, 32'h0);
    sif.mem_req_ready = 1'b0;
  endtask

  // One cycle: compare everything against the reference, advance it, clock
  task automatic step(input string tag);
    logic [NP-1:0] exp_acc;
    logic [3:0]    em;
    logic [31:0]   ed;
    logic [3:0]    be;
    logic [31:0]   wd;
    int            free;
    int            pre;
    int            allocs;
    bit            stop;
    bit            took;
    ent_t          e;
    #1;
    chk({tag, ":count"}, 32'(count), 32'(q.size()));
    chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ":req_valid"}, 32'(sif.mem_req_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ":req_addr"}, sif.mem_req_addr, {q[0].waddr, 2'b00});
      chk({tag, ":req_data"}, sif.mem_req_data, q[0].data);
      chk({tag, ":req_be"}, 32'(sif.mem_req_be), 32'(q[0].be));
    end
    for (int n = 0; n < NL; n++) begin
      em = '0;
      ed = '0;
      for (int b = 0; b < 4; b++) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].waddr == sif.ld_addr[n][31:2] && q[j].be[b]) begin
            em[b]         = 1'b1;
            ed[8*b +: 8]  = q[j].data[8*b +: 8];
            break;
          end
        end
      end
      chk($sformatf("%s:fwd_mask%0d", tag, n), 32'(sif.fwd_mask[n]), 32'(em));
      chk($sformatf("%s:fwd_data%0d", tag, n), sif.fwd_data[n], ed);
    end
    pre     = q.size();
    free    = D - pre;
    allocs  = 0;
    stop    = reset;
    exp_acc = '0;
    for (int p = 0; p < NP; p++) begin
      if (stop || !sif.sq_dcache_packet[p].valid) begin
        stop = 1'b1;
      end else begin
        place(sif.sq_dcache_packet[p].addr, sif.sq_dcache_packet[p].sign_size[1:0],
              sif.sq_dcache_packet[p].data, be, wd);
        took = 1'b0;
        if (q.size() >= 2 && q[q.size()-1].waddr == sif.sq_dcache_packet[p].addr[31:2]) begin
          e = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
          e.be = e.be | be;
          q[q.size()-1] = e;
          took = 1'b1;
        end else if (allocs < free) begin
          e.waddr = sif.sq_dcache_packet[p].addr[31:2];
          e.be    = be;
          e.data  = wd;
          q.push_back(e);
          allocs++;
          took = 1'b1;
        end
        if (took) exp_acc[p] = 1'b1;
        else      stop       = 1'b1;
      end
    end
    chk({tag, ":accept"}, 32'(sif.dcache_accept), 32'(exp_acc));
    if (reset) q.delete();
    else if (pre > 0 && sif.mem_req_ready) void'(q.pop_front());
    @(posedge clock);
    #1;
  endtask

  initial begin
    sif.ld_addr = '0;
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    step("reset");
    reset = 1'b0;

    // Single store then immediate drain
    set_port(0, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF);
    #1;
    chk("single_accept", 32'(sif.dcache_accept), 32'h1);
    step("single_a");
    idle();
    sif.mem_req_ready = 1'b1;
    #1;
    chk("single_addr", sif.mem_req_addr, 32'h100);
    chk("single_data", sif.mem_req_data, 32'hDEADBEEF);
    chk("single_be", 32'(sif.mem_req_be), 32'hF);
    step("single_b");
    step("single_c");

    // Prefix stop at a nearly full buffer
    idle();
    for (int k = 0; k < 3; k++) begin
      set_port(0, 1'b1, 32'h10 + 32'(4 * k), 2'd2, 32'(k + 1));
      step("prefix_fill");
    end
    set_port(0, 1'b1, 32'h20, 2'd2, 32'h2020);
    set_port(1, 1'b1, 32'h24, 2'd2, 32'h2424);
    #1;
    chk("prefix_accept", 32'(sif.dcache_accept), 32'h1);
    step("prefix_two");
    idle();
    set_port(0, 1'b1, 32'h24, 2'd2, 32'h2424);
    #1;
    chk("prefix_full_count", 32'(count), 32'd4);
    chk("prefix_full_accept", 32'(sif.dcache_accept), 32'h0);
    step("prefix_full");
    idle();
    sif.mem_req_ready = 1'b1;
    repeat (5) step("prefix_drain");

    // Coalescing into the youngest non-head entry
    idle();
    set_port(0, 1'b1, 32'h500, 2'd2, 32'hA5A5A5A5);
    step("coal_a");
    set_port(0, 1'b1, 32'h200, 2'd0, 32'h11);
    step("coal_b");
    set_port(0, 1'b1, 32'h201, 2'd0, 32'h22);
    #1;
    chk("coal_accept", 32'(sif.dcache_accept), 32'h1);
    step("coal_merge");
    idle();
    #1;
    chk("coal_count", 32'(count), 32'd2);
    sif.mem_req_ready = 1'b1;
    step("coal_pop_a");
    chk("coal_addr", sif.mem_req_addr, 32'h200);
    chk("coal_data", sif.mem_req_data, 32'h00002211);
    chk("coal_be", 32'(sif.mem_req_be), 32'h3);
    step("coal_pop_b");

    // A store to the head's word allocates rather than merging
    idle();
    set_port(0, 1'b1, 32'h300, 2'd0, 32'h77);
    step("head_a");
    set_port(0, 1'b1, 32'h302, 2'd0, 32'h88);
    step("head_b");
    idle();
    #1;
    chk("head_count", 32'(count), 32'd2);
    sif.mem_req_ready = 1'b1;
    repeat (3) step("head_drain");

    // Forwarding picks the youngest writer per byte
    idle();
    set_port(0, 1'b1, 32'h400, 2'd2, 32'hAABBCCDD);
    step("fwd_a");
    set_port(0, 1'b1, 32'h402, 2'd1, 32'h1234);
    step("fwd_b");
    idle();
    sif.ld_addr[0] = 32'h400;
    sif.ld_addr[1] = 32'h404;
    #1;
    chk("fwd_mask_hit", 32'(sif.fwd_mask[0]), 32'hF);
    chk("fwd_data_hit", sif.fwd_data[0], 32'h1234CCDD);
    chk("fwd_mask_miss", 32'(sif.fwd_mask[1]), 32'h0);
    step("fwd_look");
    sif.mem_req_ready = 1'b1;
    repeat (3) step("fwd_drain");

    // Allocate/drain pairs across pointer wrap, then reset with 3 entries held
    idle();
    sif.mem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_port(0, 1'b1, 32'h700 + 32'(4 * k), 2'd2, $urandom);
      step("wrap");
    end
    idle();
    sif.mem_req_ready = 1'b1;
    step("wrap_last");
    idle();
    for (int k = 0; k < 3; k++) begin
      set_port(0, 1'b1, 32'h800 + 32'(4 * k), 2'd2, $urandom);
      step("rst_fill");
    end
    idle();
    #1;
    chk("rst_pre_count", 32'(count), 32'd3);
    reset = 1'b1;
    step("rst_mid");
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req_valid", 32'(sif.mem_req_valid), 32'd0);
    step("rst_after");

    // Random traffic over a few words so merges, full stalls and forwarding mix
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        set_port(p, 1'($urandom_range(0, 3) != 0),
                 32'h600 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
                 2'($urandom_range(0, 2)), $urandom);
      end
      sif.mem_req_ready = 1'($urandom_range(0, 1));
      for (int n = 0; n < NL; n++)
        sif.ld_addr[n] = 32'h600 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
      reset = ($urandom_range(0, 63) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
